// File: rtl/tile_scan.sv
// Sequences the tile renderer over the 5x6 letter grid: raster-to-tile mapping,
// board fetch, renderer inputs, sync delay, and the row-reveal animation.
module tile_scan #(
    parameter int X0            = 120,
    parameter int Y0            = 0,
    parameter int SQUARE_LAT    = 5,
    parameter int REVEAL_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [4:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [6:0] x,
    output logic [6:0] y,
    output logic [2:0] style,
    output logic [4:0] letter,
    output logic       de_out,
    output logic       hsync_out,
    output logic       vsync_out,
    input  logic       reveal_start,
    input  logic [2:0] reveal_row,
    output logic       reveal_busy,
    output logic [2:0] reveal_col,
    output logic       reveal_done
);

    localparam int unsigned PITCH = 80;
    localparam int unsigned DLY   = 2 + SQUARE_LAT;
    localparam int unsigned FW    = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [FW-1:0] FLAST = FW'(REVEAL_FRAMES - 1);

    typedef enum logic { IDLE, FLIP } state_t;

    // ---------------- tile mapping (constant-compare chains) ----------------
    logic [10:0] h11, v11, x_base, y_base, lx_full, ly_full;
    logic [2:0]  col_c, row_c;
    logic        in_grid_c;
    logic [4:0]  addr_c;

    always_comb begin
        h11    = {1'b0, hpos};
        v11    = {1'b0, vpos};
        col_c  = '0;
        row_c  = '0;
        x_base = 11'(X0);
        y_base = 11'(Y0);
        for (int unsigned k = 1; k < 5; k++) begin
            if (h11 >= 11'(X0 + PITCH * k)) begin
                col_c  = 3'(k);
                x_base = 11'(X0 + PITCH * k);
            end
        end
        for (int unsigned k = 1; k < 6; k++) begin
            if (v11 >= 11'(Y0 + PITCH * k)) begin
                row_c  = 3'(k);
                y_base = 11'(Y0 + PITCH * k);
            end
        end
        lx_full   = h11 - x_base;
        ly_full   = v11 - y_base;
        in_grid_c = (h11 >= 11'(X0)) && (h11 < 11'(X0 + 5 * PITCH)) &&
                    (v11 >= 11'(Y0)) && (v11 < 11'(Y0 + 6 * PITCH));
        addr_c    = ({2'b00, row_c} * 5'd5) + {2'b00, col_c};
    end

    // ---------------- stage A ----------------
    logic [2:0] col_a, row_a;
    logic [6:0] lx_a, ly_a;
    logic       in_grid_a;

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_a     <= '0;
            row_a     <= '0;
            lx_a      <= '0;
            ly_a      <= '0;
            in_grid_a <= 1'b0;
            rd_addr   <= '0;
        end else begin
            col_a     <= col_c;
            row_a     <= row_c;
            lx_a      <= lx_full[6:0];
            ly_a      <= ly_full[6:0];
            in_grid_a <= in_grid_c;
            if (in_grid_c)
                rd_addr <= addr_c;
        end
    end

    // ---------------- reveal FSM ----------------
    state_t        state, state_n;
    logic [2:0]    rrow, rrow_n, rcol_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          done_n, vsync_q, vs_rise;

    assign vs_rise = vsync_in & ~vsync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rrow        <= '0;
            reveal_col  <= '0;
            fcnt        <= '0;
            reveal_done <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state       <= state_n;
            rrow        <= rrow_n;
            reveal_col  <= rcol_n;
            fcnt        <= fcnt_n;
            reveal_done <= done_n;
            vsync_q     <= vsync_in;
        end
    end

    always_comb begin
        state_n = state;
        rrow_n  = rrow;
        rcol_n  = reveal_col;
        fcnt_n  = fcnt;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (reveal_start) begin
                    rrow_n  = reveal_row;
                    rcol_n  = '0;
                    fcnt_n  = '0;
                    state_n = FLIP;
                end
            end
            FLIP: begin
                if (vs_rise) begin
                    if (fcnt == FLAST) begin
                        fcnt_n = '0;
                        rcol_n = reveal_col + 3'd1;
                        if (reveal_col == 3'd4) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign reveal_busy = (state == FLIP);

    // ---------------- stage B ----------------
    logic       override;
    logic [2:0] style_c;

    always_comb begin
        override = reveal_busy && (row_a == rrow) && (col_a >= reveal_col);
        style_c  = override ? 3'b101 : rd_data[7:5];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x      <= '0;
            y      <= '0;
            style  <= 3'b100;
            letter <= 5'd31;
        end else if (in_grid_a) begin
            x      <= lx_a;
            y      <= ly_a;
            style  <= style_c;
            letter <= rd_data[4:0];
        end else begin
            x      <= '0;
            y      <= '0;
            style  <= 3'b100;
            letter <= 5'd31;
        end
    end

    // ---------------- sync delay lines ----------------
    logic [DLY-1:0] de_sr, hs_sr, vs_sr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            de_sr <= '0;
            hs_sr <= '0;
            vs_sr <= '0;
        end else begin
            de_sr <= {de_sr[DLY-2:0], de_in};
            hs_sr <= {hs_sr[DLY-2:0], hsync_in};
            vs_sr <= {vs_sr[DLY-2:0], vsync_in};
        end
    end

    assign de_out    = de_sr[DLY-1];
    assign hsync_out = hs_sr[DLY-1];
    assign vsync_out = vs_sr[DLY-1];

endmodule

// File: tb/tb_tile_scan.sv
// Directed self-checking bench for tile_scan (REVEAL_FRAMES=2).
module tb_tile_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hpos, vpos;
    logic       de_in, hsync_in, vsync_in;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] x, y;
    logic [2:0] style;
    logic [4:0] letter;
    logic       de_out, hsync_out, vsync_out;
    logic       reveal_start;
    logic [2:0] reveal_row;
    logic       reveal_busy;
    logic [2:0] reveal_col;
    logic       reveal_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    tile_scan #(.X0(120), .Y0(0), .SQUARE_LAT(5), .REVEAL_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .x(x), .y(y), .style(style), .letter(letter),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .reveal_start(reveal_start), .reveal_row(reveal_row),
        .reveal_busy(reveal_busy), .reveal_col(reveal_col), .reveal_done(reveal_done)
    );

    always @(negedge clk) if (reveal_done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_edge();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({x, y, rd_addr} !== 19'd0) begin
            errors++; $display("FAIL reset_xy_addr: x=%0d y=%0d addr=%0d, want 0 0 0", x, y, rd_addr);
        end
        checks++;
        if (style !== 3'd4 || letter !== 5'd31) begin
            errors++; $display("FAIL reset_style: style=%0d letter=%0d, want 4 31", style, letter);
        end
        checks++;
        if ({de_out, hsync_out, vsync_out, reveal_busy, reveal_col, reveal_done} !== 8'd0) begin
            errors++; $display("FAIL reset_misc: de/hs/vs=%b%b%b busy=%b col=%0d done=%b, want all 0",
                               de_out, hsync_out, vsync_out, reveal_busy, reveal_col, reveal_done);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        hpos = 10'd310; vpos = 10'd265; rd_data = 8'h63;
        step();
        checks++;
        if (rd_addr !== 5'd17) begin
            errors++; $display("FAIL fetch_addr: got %0d want 17", rd_addr);
        end
        step();
        checks++;
        if (x !== 7'd30 || y !== 7'd25) begin
            errors++; $display("FAIL fetch_xy: got %0d,%0d want 30,25", x, y);
        end
        checks++;
        if (style !== 3'd3 || letter !== 5'd3) begin
            errors++; $display("FAIL fetch_style: got %0d/%0d want 3/3", style, letter);
        end
    endtask

    task automatic test_edges();
        vpos = 10'd265; rd_data = 8'h63;
        hpos = 10'd119; step(); step();
        checks++;
        if (x !== 7'd0 || y !== 7'd0 || style !== 3'd4 || letter !== 5'd31) begin
            errors++; $display("FAIL edge_119: x=%0d y=%0d st=%0d lt=%0d want 0 0 4 31", x, y, style, letter);
        end
        hpos = 10'd120; step();
        checks++;
        if (rd_addr !== 5'd15) begin
            errors++; $display("FAIL edge_120_addr: got %0d want 15", rd_addr);
        end
        step();
        checks++;
        if (x !== 7'd0 || y !== 7'd25 || style !== 3'd3) begin
            errors++; $display("FAIL edge_120: x=%0d y=%0d st=%0d want 0 25 3", x, y, style);
        end
        hpos = 10'd519; step();
        checks++;
        if (rd_addr !== 5'd19) begin
            errors++; $display("FAIL edge_519_addr: got %0d want 19", rd_addr);
        end
        step();
        checks++;
        if (x !== 7'd79 || style !== 3'd3) begin
            errors++; $display("FAIL edge_519: x=%0d st=%0d want 79 3", x, style);
        end
        hpos = 10'd520; step(); step();
        checks++;
        if (x !== 7'd0 || y !== 7'd0 || style !== 3'd4 || letter !== 5'd31 || rd_addr !== 5'd19) begin
            errors++; $display("FAIL edge_520: x=%0d y=%0d st=%0d lt=%0d addr=%0d want 0 0 4 31 19",
                               x, y, style, letter, rd_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] hs [3] = '{10'd125, 10'd210, 10'd300};
        logic [4:0] ea [3] = '{5'd0, 5'd1, 5'd2};
        logic [6:0] ex [3] = '{7'd5, 7'd10, 7'd20};
        vpos = 10'd5;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) hpos = hs[i];
            step();
            if (i < 3) begin
                checks++;
                if (rd_addr !== ea[i]) begin
                    errors++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, rd_addr, ea[i]);
                end
            end
            if (i >= 1) begin
                checks++;
                if (x !== ex[i-1] || y !== 7'd5) begin
                    errors++; $display("FAIL b2b_xy[%0d]: got %0d,%0d want %0d,5", i-1, x, y, ex[i-1]);
                end
            end
        end
    endtask

    task automatic test_sync_delay();
        hsync_in = 1'b1;
        step();
        hsync_in = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            // k edges after the pulse was launched; output high only after edge 7
            checks++;
            if (hsync_out !== (k == 7)) begin
                errors++; $display("FAIL sync_delay[%0d]: hsync_out=%b want %b", k, hsync_out, (k == 7));
            end
            if (k < 9) step();
        end
    endtask

    task automatic test_reveal();
        int start_done;
        hpos = 10'd365; vpos = 10'd165; rd_data = 8'h47;
        start_done = done_cnt;
        reveal_row = 3'd2; reveal_start = 1'b1;
        step();
        reveal_start = 1'b0;
        step();
        checks++;
        if (reveal_busy !== 1'b1 || reveal_col !== 3'd0 || style !== 3'd5) begin
            errors++; $display("FAIL reveal_start: busy=%b col=%0d st=%0d want 1 0 5", reveal_busy, reveal_col, style);
        end
        for (int e = 1; e <= 10; e++) begin
            if (e == 3) begin
                reveal_row = 3'd0; reveal_start = 1'b1;
                step();
                reveal_start = 1'b0;
            end
            vsync_edge();
            checks++;
            if (reveal_col !== ((e == 10) ? 3'd5 : 3'(e / 2))) begin
                errors++; $display("FAIL reveal_col[%0d]: got %0d want %0d", e, reveal_col, (e == 10) ? 5 : e / 2);
            end
            checks++;
            if (reveal_busy !== (e < 10)) begin
                errors++; $display("FAIL reveal_busy[%0d]: got %b want %b", e, reveal_busy, (e < 10));
            end
            checks++;
            if (style !== ((e < 8) ? 3'd5 : 3'd2) || letter !== 5'd7) begin
                errors++; $display("FAIL reveal_tile[%0d]: st=%0d lt=%0d want %0d 7", e, style, letter, (e < 8) ? 5 : 2);
            end
        end
        step();
        checks++;
        if (done_cnt - start_done !== 1) begin
            errors++; $display("FAIL reveal_done_count: got %0d want 1", done_cnt - start_done);
        end
    endtask

    task automatic test_reset_mid_reveal();
        int start_done;
        start_done = done_cnt;
        reveal_row = 3'd1; reveal_start = 1'b1;
        step();
        reveal_start = 1'b0;
        repeat (3) vsync_edge();
        checks++;
        if (reveal_busy !== 1'b1 || reveal_col !== 3'd1) begin
            errors++; $display("FAIL midrev_pre: busy=%b col=%0d want 1 1", reveal_busy, reveal_col);
        end
        rst = 1'b0;
        step();
        checks++;
        if (reveal_busy !== 1'b0 || reveal_col !== 3'd0 || style !== 3'd4 || letter !== 5'd31) begin
            errors++; $display("FAIL midrev_reset: busy=%b col=%0d st=%0d lt=%0d want 0 0 4 31",
                               reveal_busy, reveal_col, style, letter);
        end
        rst = 1'b1;
        repeat (4) step();
        checks++;
        if (done_cnt !== start_done || reveal_busy !== 1'b0) begin
            errors++; $display("FAIL midrev_done: pulses=%0d busy=%b want 0 0", done_cnt - start_done, reveal_busy);
        end
    endtask

    initial begin
        rst = 1'b0; hpos = '0; vpos = '0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        rd_data = '0; reveal_start = 1'b0; reveal_row = '0;
        test_reset();
        test_fetch();
        test_edges();
        test_back_to_back();
        test_sync_delay();
        test_reveal();
        test_reset_mid_reveal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
